// File: rtl/unidad_busqueda.sv
// Instruction-fetch unit: owns the PC, issues one instruction-memory request
// at a time, captures the returned word and hands {PCInstr, Instr} to decode.
// Redirects take priority over every other event; a response that belongs to
// a request issued before a redirect is dropped through the Descartar flag.
module unidad_busqueda #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Stall,
    input  logic            Redirigir,
    input  logic [XLEN-1:0] PCDestino,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemReady,
    input  logic            ImemRspValid,
    input  logic [XLEN-1:0] ImemRdata,
    output logic            InstrValid,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PCInstr,
    input  logic            InstrReady,
    output logic            ErrorAlineacion
);

    localparam logic [2:0] INICIO  = 3'd0;
    localparam logic [2:0] PEDIR   = 3'd1;
    localparam logic [2:0] ESPERA  = 3'd2;
    localparam logic [2:0] ENTREGA = 3'd3;
    localparam logic [2:0] ERROR   = 3'd4;

    logic [2:0]      state;
    logic [XLEN-1:0] pc;
    logic            descartar;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_instr_q;

    // A misaligned target in these situations leaves a request whose
    // response is still on its way; remember to drop it.
    logic abandona_peticion;
    assign abandona_peticion = (state == PEDIR && ImemReady) ||
                               (state == ESPERA && !ImemRspValid);

    // All outputs come from registers or from the state decode only.
    assign ImemReq         = (state == PEDIR);
    assign ImemAddr        = pc;
    assign InstrValid      = (state == ENTREGA);
    assign ErrorAlineacion = (state == ERROR);
    assign Instr           = instr_q;
    assign PCInstr         = pc_instr_q;

    // Fetch sequencer, PC, stale-response flag and the delivered-word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INICIO;
            pc         <= RESET_VECTOR;
            descartar  <= 1'b0;
            instr_q    <= '0;
            pc_instr_q <= '0;
        end else begin
            // A response seen outside ESPERA can only be the leftover of a
            // request abandoned on the way into ERROR; it consumes the flag.
            if (state != ESPERA && ImemRspValid) begin
                descartar <= 1'b0;
            end

            if (Redirigir) begin
                if (PCDestino[1:0] != 2'b00) begin
                    state <= ERROR;
                    if (abandona_peticion) begin
                        descartar <= 1'b1;
                    end else if (state == ESPERA) begin
                        descartar <= 1'b0;
                    end
                end else begin
                    pc <= PCDestino;
                    case (state)
                        PEDIR: begin
                            if (ImemReady) begin
                                descartar <= 1'b1;
                                state     <= ESPERA;
                            end else begin
                                state <= PEDIR;
                            end
                        end
                        ESPERA: begin
                            if (ImemRspValid) begin
                                descartar <= 1'b0;
                                state     <= PEDIR;
                            end else begin
                                descartar <= 1'b1;
                            end
                        end
                        default: state <= PEDIR;
                    endcase
                end
            end else begin
                case (state)
                    INICIO: begin
                        if (!Stall) begin
                            state <= PEDIR;
                        end
                    end
                    PEDIR: begin
                        if (ImemReady) begin
                            state <= ESPERA;
                        end
                    end
                    ESPERA: begin
                        if (ImemRspValid) begin
                            if (descartar) begin
                                descartar <= 1'b0;
                                state     <= Stall ? INICIO : PEDIR;
                            end else begin
                                instr_q    <= ImemRdata;
                                pc_instr_q <= pc;
                                state      <= ENTREGA;
                            end
                        end
                    end
                    ENTREGA: begin
                        if (InstrReady) begin
                            pc    <= pc + 32'd4;
                            state <= Stall ? INICIO : PEDIR;
                        end
                    end
                    ERROR: state <= ERROR;
                    default: state <= INICIO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_unidad_busqueda.sv
// Directed bench for the fetch unit: a small memory responder with
// programmable latency answers each accepted request with 0x0001_0000 + addr
// (or 0xDEADBEEF when forced), and the main sequence walks through reset,
// streaming, back-pressure, redirects, misalignment, wrap-around and stall.
module tb_unidad_busqueda;

    logic        clk;
    logic        rst_n;
    logic        Stall;
    logic        Redirigir;
    logic [31:0] PCDestino;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        ImemRspValid;
    logic [31:0] ImemRdata;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] PCInstr;
    logic        InstrReady;
    logic        ErrorAlineacion;

    int total = 0;
    int bad   = 0;

    int          lat = 1;
    logic        force_dead = 1'b0;
    int          cnt = 0;
    logic [31:0] addr_q = '0;
    logic        stale_seen = 1'b0;

    unidad_busqueda #(.RESET_VECTOR(32'h0000_0000), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Stall          (Stall),
        .Redirigir      (Redirigir),
        .PCDestino      (PCDestino),
        .ImemReq        (ImemReq),
        .ImemAddr       (ImemAddr),
        .ImemReady      (ImemReady),
        .ImemRspValid   (ImemRspValid),
        .ImemRdata      (ImemRdata),
        .InstrValid     (InstrValid),
        .Instr          (Instr),
        .PCInstr        (PCInstr),
        .InstrReady     (InstrReady),
        .ErrorAlineacion(ErrorAlineacion)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: latency counted from the accepting edge.
    always @(posedge clk) begin
        logic        acc;
        logic [31:0] a;
        acc = ImemReq && ImemReady;
        a   = ImemAddr;
        #1;
        ImemRspValid = 1'b0;
        if (acc) begin
            cnt    = lat;
            addr_q = a;
        end
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                ImemRspValid = 1'b1;
                ImemRdata    = force_dead ? 32'hDEAD_BEEF : (32'h0001_0000 + addr_q);
            end
        end
    end

    // One line per delivered instruction; flag any stale word shown to decode.
    always @(posedge clk) begin
        if (rst_n && InstrValid && InstrReady && !Redirigir)
            $display("deliver pc=%h instr=%h", PCInstr, Instr);
    end

    always @(negedge clk) begin
        if (InstrValid && Instr == 32'hDEAD_BEEF) stale_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!InstrValid && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!InstrValid) check("timeout_valid", {31'd0, InstrValid}, 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        Stall        = 1'b0;
        Redirigir    = 1'b0;
        PCDestino    = '0;
        ImemReady    = 1'b1;
        InstrReady   = 1'b1;
        ImemRspValid = 1'b0;
        ImemRdata    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req",   {31'd0, ImemReq}, 32'd0);
        check("rst_valid", {31'd0, InstrValid}, 32'd0);
        check("rst_instr", Instr, 32'd0);
        check("rst_pci",   PCInstr, 32'd0);
        check("rst_err",   {31'd0, ErrorAlineacion}, 32'd0);
        check("rst_addr",  ImemAddr, 32'd0);
        rst_n = 1'b1;

        // Streaming fetch with zero-wait memory
        @(negedge clk);
        check("c0_req",  {31'd0, ImemReq}, 32'd1);
        check("c0_addr", ImemAddr, 32'h0);
        @(negedge clk);
        check("c1_req",  {31'd0, ImemReq}, 32'd0);
        @(negedge clk);
        check("c2_valid", {31'd0, InstrValid}, 32'd1);
        check("c2_pci",   PCInstr, 32'h0);
        check("c2_instr", Instr, 32'h0001_0000);
        @(negedge clk);
        check("c3_req",  {31'd0, ImemReq}, 32'd1);
        check("c3_addr", ImemAddr, 32'h4);
        repeat (2) @(negedge clk);
        check("c5_pci",   PCInstr, 32'h4);
        check("c5_instr", Instr, 32'h0001_0004);
        repeat (3) @(negedge clk);
        check("c8_valid", {31'd0, InstrValid}, 32'd1);
        check("c8_pci",   PCInstr, 32'h8);
        check("c8_instr", Instr, 32'h0001_0008);

        // Back-pressure from decode
        InstrReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, InstrValid}, 32'd1);
            check("bp_pci",   PCInstr, 32'h8);
            check("bp_instr", Instr, 32'h0001_0008);
            check("bp_req",   {31'd0, ImemReq}, 32'd0);
            check("bp_addr",  ImemAddr, 32'h8);
        end
        InstrReady = 1'b1;
        @(negedge clk);
        check("bp_next_req",  {31'd0, ImemReq}, 32'd1);
        check("bp_next_addr", ImemAddr, 32'hC);

        // Redirect while waiting; the late response must be dropped
        lat        = 3;
        force_dead = 1'b1;
        @(negedge clk);
        check("rd_wait_req", {31'd0, ImemReq}, 32'd0);
        Redirigir = 1'b1;
        PCDestino = 32'h100;
        @(negedge clk);
        Redirigir = 1'b0;
        check("rd_addr", ImemAddr, 32'h100);
        check("rd_req",  {31'd0, ImemReq}, 32'd0);
        @(negedge clk);
        force_dead = 1'b0;
        lat        = 1;
        @(negedge clk);
        check("rd_new_req",  {31'd0, ImemReq}, 32'd1);
        check("rd_new_addr", ImemAddr, 32'h100);
        wait_valid(10);
        check("rd_pci",   PCInstr, 32'h100);
        check("rd_instr", Instr, 32'h0001_0100);

        // Misaligned redirect (preempts the pending accept)
        Redirigir = 1'b1;
        PCDestino = 32'h102;
        @(negedge clk);
        Redirigir = 1'b0;
        check("mis_err",   {31'd0, ErrorAlineacion}, 32'd1);
        check("mis_valid", {31'd0, InstrValid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mis_err_hold", {31'd0, ErrorAlineacion}, 32'd1);
            check("mis_req_hold", {31'd0, ImemReq}, 32'd0);
        end
        Redirigir = 1'b1;
        PCDestino = 32'h200;
        @(negedge clk);
        Redirigir = 1'b0;
        check("fix_err",  {31'd0, ErrorAlineacion}, 32'd0);
        check("fix_req",  {31'd0, ImemReq}, 32'd1);
        check("fix_addr", ImemAddr, 32'h200);
        wait_valid(10);
        check("fix_pci",   PCInstr, 32'h200);
        check("fix_instr", Instr, 32'h0001_0200);

        // PC wrap-around
        Redirigir = 1'b1;
        PCDestino = 32'hFFFF_FFFC;
        @(negedge clk);
        Redirigir = 1'b0;
        check("wr_addr", ImemAddr, 32'hFFFF_FFFC);
        wait_valid(10);
        check("wr_pci",   PCInstr, 32'hFFFF_FFFC);
        check("wr_instr", Instr, 32'h0000_FFFC);
        @(negedge clk);
        check("wr_req",  {31'd0, ImemReq}, 32'd1);
        check("wr_next", ImemAddr, 32'h0);

        // Stall raised while waiting
        lat = 2;
        @(negedge clk);
        check("st_wait_req", {31'd0, ImemReq}, 32'd0);
        Stall = 1'b1;
        @(negedge clk);
        check("st_wait_valid", {31'd0, InstrValid}, 32'd0);
        @(negedge clk);
        check("st_valid", {31'd0, InstrValid}, 32'd1);
        check("st_pci",   PCInstr, 32'h0);
        check("st_instr", Instr, 32'h0001_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("st_req_low", {31'd0, ImemReq}, 32'd0);
            check("st_addr",    ImemAddr, 32'h4);
        end
        Stall = 1'b0;
        @(negedge clk);
        check("st_resume_req",  {31'd0, ImemReq}, 32'd1);
        check("st_resume_addr", ImemAddr, 32'h4);

        // Asynchronous reset in the middle of a wait
        lat = 3;
        @(negedge clk);
        check("ar_wait_req", {31'd0, ImemReq}, 32'd0);
        check("ar_pre_instr", Instr, 32'h0001_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req",   {31'd0, ImemReq}, 32'd0);
        check("ar_valid", {31'd0, InstrValid}, 32'd0);
        check("ar_instr", Instr, 32'd0);
        check("ar_pci",   PCInstr, 32'd0);
        check("ar_addr",  ImemAddr, 32'd0);
        check("ar_err",   {31'd0, ErrorAlineacion}, 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_restart_req", {31'd0, ImemReq}, 32'd1);

        check("no_stale_word", {31'd0, stale_seen}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidad_busqueda.md
Name: unidad_busqueda

Overview:
- Instruction-fetch unit for the RISC-V core. It owns the architectural PC register and consumes the sequential next address (PC+4).
- Drives read requests to instruction memory with a valid/ready handshake and captures the returned word.
- Presents {PCInstr, Instr} to decode with its own valid/ready handshake.
- Accepts redirects (branch/jump targets) and discards stale in-flight responses.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- XLEN, 32, address/instruction width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- Stall  in  1  1 = do not issue a new fetch request. In-flight requests complete normally.
- Redirigir  in  1  1 = load PCDestino as the next fetch address this cycle.
- PCDestino  in  32  redirect target.
- ImemReq  out  1  request valid to instruction memory.
- ImemAddr  out  32  request address; equals the PC register.
- ImemReady  in  1  memory accepts the request when ImemReq && ImemReady.
- ImemRspValid  in  1  response word valid; at most one response per accepted request, no earlier than the cycle after acceptance.
- ImemRdata  in  32  response word.
- InstrValid  out  1  instruction valid to decode.
- Instr  out  32  fetched instruction.
- PCInstr  out  32  address of Instr.
- InstrReady  in  1  decode accepts when InstrValid && InstrReady.
- ErrorAlineacion  out  1  misaligned redirect target; sticky until cleared.

Behaviour:
- Reset (async assert, sync deassert): state=INICIO, PC=RESET_VECTOR, Descartar=0. ImemReq=0, InstrValid=0, Instr=0, PCInstr=0, ErrorAlineacion=0. Asserting reset mid-transaction abandons it.
- ImemAddr = PC at all times. All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- INICIO: one cycle, then PEDIR. If Stall=1, stay in INICIO.
- PEDIR: ImemReq=1. On ImemReady=1, go to ESPERA. Stall is ignored once in PEDIR; the request is not withdrawn.
- ESPERA: wait for ImemRspValid.
  - If Descartar=0: capture Instr<=ImemRdata, PCInstr<=PC, go to ENTREGA.
  - If Descartar=1: drop the word, clear Descartar, go to PEDIR (or INICIO if Stall=1).
- ENTREGA: InstrValid=1. Instr and PCInstr are held stable until accepted.
  - On InstrReady=1: PC<=PC+32'd4, with wrap-around 32'hFFFF_FFFC -> 32'h0000_0000 and no flag.
  - Next state is PEDIR, or INICIO if Stall=1.
- ERROR: ErrorAlineacion=1, ImemReq=0, InstrValid=0. Leaves only on an aligned redirect (to PEDIR) or on reset.
- Redirect (Redirigir=1) has priority over every other event in the same cycle, including accept and response:
  - PCDestino[1:0]!=0: go to ERROR, PC unchanged, no request issued.
  - INICIO/PEDIR/ENTREGA/ERROR: PC<=PCDestino, InstrValid drops next cycle, go to PEDIR.
  - PEDIR with ImemReady=1 in the same cycle: the old request was accepted, so set Descartar=1 and go to ESPERA. PC<=PCDestino.
  - ESPERA with no response this cycle: PC<=PCDestino, Descartar<=1, stay in ESPERA.
  - ESPERA with ImemRspValid=1 in the same cycle: drop the word, PC<=PCDestino, go to PEDIR.
  - Any aligned redirect clears ErrorAlineacion.
- Throughput: best case one instruction per 3 cycles (PEDIR, ESPERA, ENTREGA) with zero-wait memory. Only one outstanding request at a time.

Test Plan:
- Reset release, RESET_VECTOR=0, ImemReady=1, response 1 cycle later, InstrReady=1.
  - ImemReq rises 1 cycle after reset release with ImemAddr=0.
  - Instructions are delivered with PCInstr=0,4,8; the instruction at PC=4 is first requested 3 cycles after that at PC=0.
- Hold InstrReady=0 for 5 cycles in ENTREGA.
  - InstrValid, Instr and PCInstr stay stable.
  - PC does not advance and no new ImemReq is issued.
- Redirigir=1, PCDestino=0x100 while in ESPERA; the response arrives 2 cycles later with 0xDEADBEEF.
  - That word is never presented on Instr.
  - The next request is to 0x100 and the next PCInstr is 0x100.
- Redirigir=1, PCDestino=0x102.
  - ErrorAlineacion=1 and ImemReq=0 until a redirect to 0x200.
  - After that redirect, ErrorAlineacion clears and ImemAddr=0x200.
- Redirect to 0xFFFF_FFFC, then accept that instruction.
  - The next ImemAddr is 0x0000_0000.
- Stall=1 asserted during ESPERA.
  - The in-flight response is still delivered.
  - After acceptance, ImemReq stays 0 until Stall=0, then rises the cycle after Stall drops (via INICIO).
  - Reset asserted while in ESPERA: all outputs go to reset values immediately (asynchronously).
